vga_scanout: RTL and testbench
==============================

# vga_scanout

Display-side reader for the video framebuffer that the instruction-ROM-driven processor fills through its `VGA` instruction. It generates 640x480@60 Hz VGA timing from the 50 MHz system clock using an internal divide-by-2 pixel enable. It reads the 100x100 framebuffer through a synchronous-read port and scales each cell 4x4, producing a 400x400 image in the top-left corner of the screen. All pixels outside that image, and all blanking intervals, are driven black.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch and sync widths, in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical porch and sync widths, in lines
- FB_COLS, 100; FB_ROWS, 100: framebuffer dimensions
- SCALE_SHIFT, 2: log2 of the screen pixels per framebuffer cell, per axis
- Clock  input  1  50 MHz system clock; all logic on the rising edge
- Reset  input  1  synchronous, active-high
- oFbAddress  output  14  framebuffer read address, row*FB_COLS+col
- iFbColor  input  3  framebuffer read data {R,G,B}; valid exactly 1 Clock after oFbAddress
- oVGA_HS  output  1  horizontal sync, active low
- oVGA_VS  output  1  vertical sync, active low
- oVGA_R, oVGA_G, oVGA_B  output  1 each  pixel color
- oFrameStart  output  1  one-Clock pulse when the counters wrap to (0,0)

## Operation
- **Pixel enable.** rPixelEn is cleared by Reset and toggles every Clock. All counters and pipeline stages advance only in cycles where rPixelEn=1.
- **Counters.**
  - hcount runs 0..799 and wraps to 0.
  - vcount runs 0..524. It increments when hcount wraps and wraps to 0 after 524.
  - Both counters are 10 bits and are compared against parameter sums; no hardcoded values.
- **Stage 0 (combinational from the counters).**
  - col = hcount>>SCALE_SHIFT; row = vcount>>SCALE_SHIFT.
  - inImage = (col<FB_COLS) && (row<FB_ROWS).
  - hsRaw = low while hcount is in [656,751].
  - vsRaw = low while vcount is in [490,491].
  - visible = (hcount<640) && (vcount<480).
- **Stage 1 (registered).**
  - oFbAddress = inImage ? row*100+col : 0. The row*100 product is computed as (row<<6)+(row<<5)+(row<<2) and is at most 9999, so 14 bits suffice.
  - hsRaw, vsRaw, and (visible && inImage) are registered alongside it.
- **Stage 2 (registered).**
  - oVGA_R/G/B = iFbColor[2]/[1]/[0] when the delayed flag is 1; otherwise 0.
  - oVGA_HS and oVGA_VS take the stage-1 copies.
  - Syncs and color therefore stay aligned, two pixel periods behind the counters.
- **Framebuffer read timing.** iFbColor is sampled at the stage-2 enable, which is two Clocks after stage 1 updates. This satisfies the 1-Clock read latency with one Clock of margin.
- **Write-side independence.** The write side (the processor's `VGA` instruction) uses the other port of the memory. This block never writes it and never stalls.

## Timing
- **Reset values (in the cycle after Reset is sampled high):**
  - rPixelEn=0, hcount=0, vcount=0.
  - oFbAddress=0.
  - oVGA_HS=1, oVGA_VS=1.
  - oVGA_R/G/B=0.
  - oFrameStart=0.
- **First count.** The first counter increment occurs at the second rising edge after Reset deasserts.
- **Line and frame periods.**
  - Line = 800 pixels = 1600 Clocks.
  - Frame = 525 lines = 840000 Clocks.
- **Sync widths.**
  - oVGA_HS is low for 96 pixels (192 Clocks) per line.
  - oVGA_VS is low for 2 lines (3200 Clocks) per frame.
- **Latency.**
  - Counter to oFbAddress: 1 pixel period.
  - Counter to RGB/HS/VS: 2 pixel periods (4 Clocks).
- **oFrameStart.** High for exactly one Clock: the Clock in which hcount and vcount both wrap to 0.
- **Reset mid-frame.** The state is abandoned immediately and reset values apply. No partial line completes.

## Test plan
- **Reset values.** Hold Reset for 5 Clocks, then release -> all outputs at their reset values; oFbAddress=0 until the first enable; first hcount increment on the second edge after release.
- **Horizontal sync.** Free-run one line -> oVGA_HS falling edges 1600 Clocks apart, low width 192 Clocks; falling edge 4 Clocks after hcount reaches 656.
- **Vertical sync and frame pulse.** Free-run two frames -> oVGA_VS low for 3200 Clocks; VS falling edges 840000 Clocks apart; exactly one oFrameStart pulse per frame.
- **Address sequence.**
  - Line 0 -> oFbAddress sequence 0,0,0,0,1,1,1,1,... up to 99 at hcount 396..399, then 0.
  - Lines 4..7 -> addresses start at 100.
  - Line 399, hcount 396 -> address 9999.
- **Image masking.** Memory model returns iFbColor=3'b111 everywhere -> RGB=1 only for hcount<400 and vcount<400 (with the 2-pixel delay); RGB=0 for hcount 400..799 and vcount ≥ 400, including all blanking.
- **Reset mid-frame.** Assert Reset at vcount 200, hcount 300 for 1 Clock -> next cycle counters are 0, HS=VS=1, RGB=0; the timing then restarts with a correct first line.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 Hz scan-out of the 100x100 video framebuffer.
// Each framebuffer cell is magnified 4x4 into the top-left 400x400 of the
// screen; everything else, including all blanking, is driven black.
// A divide-by-2 enable derives the pixel rate from the system clock, and a
// two-stage pipeline keeps address, sync and color aligned.
module vga_scanout #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int FB_COLS     = 100,
  parameter int FB_ROWS     = 100,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [13:0] oFbAddress,
  input  logic [2:0]  iFbColor,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_R,
  output logic        oVGA_G,
  output logic        oVGA_B,
  output logic        oFrameStart
);

  // Timing landmarks, all derived from the porch/sync parameters.
  localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] COL_LIMIT    = 10'(FB_COLS);
  localparam logic [9:0] ROW_LIMIT    = 10'(FB_ROWS);

  // Start address of a framebuffer row. For the 100-column buffer the
  // product is built from shifts (64+32+4) so no multiplier is needed.
  function automatic logic [13:0] row_base(input logic [9:0] row);
    logic [13:0] r;
    r = {4'b0000, row};
    if (FB_COLS == 100) begin
      return (r << 6) + (r << 5) + (r << 2);
    end else begin
      return r * 14'(FB_COLS);
    end
  endfunction

  // Linear framebuffer address of cell (row, col).
  function automatic logic [13:0] fb_address(input logic [9:0] row, input logic [9:0] col);
    return row_base(row) + {4'b0000, col};
  endfunction

  // Pixel enable and raster counters.
  logic       pixel_en_r;
  logic [9:0] hcount_r;
  logic [9:0] vcount_r;
  logic       frame_start_r;

  logic [9:0] hcount_nxt_s;
  logic [9:0] vcount_nxt_s;
  logic       h_wrap_s;
  logic       v_wrap_s;
  logic       frame_start_nxt_s;

  // Stage 0: decode of the current counter position.
  logic [9:0] col_s;
  logic [9:0] row_s;
  logic       in_image_s;
  logic       visible_s;
  logic       hs_raw_s;
  logic       vs_raw_s;
  logic [13:0] addr_nxt_s;

  // Stage 1: framebuffer address plus the timing flags travelling with it.
  logic [13:0] fb_addr_r;
  logic        hs_s1_r;
  logic        vs_s1_r;
  logic        show_s1_r;

  // Stage 2: final pixel outputs.
  logic        hs_s2_r;
  logic        vs_s2_r;
  logic [2:0]  rgb_s2_r;
  logic [2:0]  rgb_nxt_s;

  // Pixel enable: toggles every clock, giving the 25 MHz pixel rate.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pixel_en_r <= 1'b0;
    end else begin
      pixel_en_r <= ~pixel_en_r;
    end
  end

  // Next raster position and the frame-wrap condition.
  always_comb begin
    h_wrap_s          = (hcount_r == H_LAST);
    v_wrap_s          = (vcount_r == V_LAST);
    hcount_nxt_s      = hcount_r;
    vcount_nxt_s      = vcount_r;
    frame_start_nxt_s = 1'b0;
    if (pixel_en_r) begin
      if (h_wrap_s) begin
        hcount_nxt_s = 10'd0;
        if (v_wrap_s) begin
          vcount_nxt_s      = 10'd0;
          frame_start_nxt_s = 1'b1;
        end else begin
          vcount_nxt_s = vcount_r + 10'd1;
        end
      end else begin
        hcount_nxt_s = hcount_r + 10'd1;
      end
    end else begin
      hcount_nxt_s = hcount_r;
    end
  end

  // Raster counter registers; the frame pulse lands in the cycle they read (0,0).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hcount_r      <= 10'd0;
      vcount_r      <= 10'd0;
      frame_start_r <= 1'b0;
    end else begin
      hcount_r      <= hcount_nxt_s;
      vcount_r      <= vcount_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  // Stage 0 decode: cell coordinates, image window, sync and visible area.
  always_comb begin
    col_s      = hcount_r >> SCALE_SHIFT;
    row_s      = vcount_r >> SCALE_SHIFT;
    in_image_s = (col_s < COL_LIMIT) && (row_s < ROW_LIMIT);
    visible_s  = (hcount_r < H_VIS_END) && (vcount_r < V_VIS_END);
    hs_raw_s   = !((hcount_r >= H_SYNC_FIRST) && (hcount_r <= H_SYNC_LAST));
    vs_raw_s   = !((vcount_r >= V_SYNC_FIRST) && (vcount_r <= V_SYNC_LAST));
    if (in_image_s) begin
      addr_nxt_s = fb_address(row_s, col_s);
    end else begin
      addr_nxt_s = 14'd0;
    end
  end

  // Stage 1 register: issue the framebuffer read and carry the flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fb_addr_r <= 14'd0;
      hs_s1_r   <= 1'b1;
      vs_s1_r   <= 1'b1;
      show_s1_r <= 1'b0;
    end else if (pixel_en_r) begin
      fb_addr_r <= addr_nxt_s;
      hs_s1_r   <= hs_raw_s;
      vs_s1_r   <= vs_raw_s;
      show_s1_r <= visible_s && in_image_s;
    end else begin
      fb_addr_r <= fb_addr_r;
      hs_s1_r   <= hs_s1_r;
      vs_s1_r   <= vs_s1_r;
      show_s1_r <= show_s1_r;
    end
  end

  // Stage 2 color select: read data arrives two clocks after the address,
  // one more than the memory needs; outside the image the pixel is black.
  always_comb begin
    if (show_s1_r) begin
      rgb_nxt_s = iFbColor;
    end else begin
      rgb_nxt_s = 3'b000;
    end
  end

  // Stage 2 register: color and syncs leave together, two pixels behind the counters.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hs_s2_r  <= 1'b1;
      vs_s2_r  <= 1'b1;
      rgb_s2_r <= 3'b000;
    end else if (pixel_en_r) begin
      hs_s2_r  <= hs_s1_r;
      vs_s2_r  <= vs_s1_r;
      rgb_s2_r <= rgb_nxt_s;
    end else begin
      hs_s2_r  <= hs_s2_r;
      vs_s2_r  <= vs_s2_r;
      rgb_s2_r <= rgb_s2_r;
    end
  end

  assign oFbAddress  = fb_addr_r;
  assign oVGA_HS     = hs_s2_r;
  assign oVGA_VS     = vs_s2_r;
  assign oVGA_R      = rgb_s2_r[2];
  assign oVGA_G      = rgb_s2_r[1];
  assign oVGA_B      = rgb_s2_r[0];
  assign oFrameStart = frame_start_r;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout. Horizontal timing is the real 800-pixel line; the
// vertical timing and framebuffer height are shortened (13-line frame, two
// framebuffer rows) so that whole frames fit in a short run. Expected values
// come from a closed-form position model (pixel index = cycles since reset / 2)
// pushed into latency queues and popped as the DUT produces each cycle.
module tb_vga_scanout;
  localparam int H_VISIBLE = 640, H_FRONT = 16, H_SYNC = 96, H_BACK = 48;
  localparam int V_VISIBLE = 9, V_FRONT = 1, V_SYNC = 2, V_BACK = 1;
  localparam int FB_COLS = 100, FB_ROWS = 2, SCALE_SHIFT = 2;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int LINE_CLK = 2 * H_TOTAL;
  localparam int FRAME_CLK = LINE_CLK * V_TOTAL;
  localparam int HS_FALL0 = 2 * (H_VISIBLE + H_FRONT) + 4;
  localparam int VS_FALL0 = 2 * (V_VISIBLE + V_FRONT) * H_TOTAL + 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  iFbColor = 3'b000;
  logic [13:0] oFbAddress;
  logic        oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFrameStart;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hm = 0;
  int vm = 0;
  logic all_ones = 1'b0;
  logic [13:0] addr_q[$];
  logic [4:0]  pix_q[$];
  logic [13:0] exp_addr;
  logic [4:0]  exp_pix;
  logic        exp_fs;

  vga_scanout #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .FB_COLS(FB_COLS), .FB_ROWS(FB_ROWS), .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .oFbAddress(oFbAddress), .iFbColor(iFbColor),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_R(oVGA_R), .oVGA_G(oVGA_G),
    .oVGA_B(oVGA_B), .oFrameStart(oFrameStart)
  );

  always #10 Clock = ~Clock;

  // Framebuffer contents: either a per-address pattern or all white.
  function automatic logic [2:0] cell_color(input logic [13:0] a);
    if (all_ones) return 3'b111;
    return a[2:0] ^ a[5:3];
  endfunction

  // Synchronous-read memory model, one clock of latency.
  always @(posedge Clock) iFbColor <= cell_color(oFbAddress);

  // Watchdog against a stuck run.
  initial begin
    #4000000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1);
  end

  // Advance one clock, update the position model, push/pop expectations,
  // and return at the falling edge for sampling.
  task automatic tick();
    int k, h, v, col, row;
    logic in_img, vis, hs, vs;
    logic [13:0] a;
    logic [2:0] rgb;
    @(posedge Clock);
    if (Reset) begin
      cyc = 0;
      addr_q.delete();
      pix_q.delete();
      repeat (2) addr_q.push_back(14'd0);
      repeat (4) pix_q.push_back(5'b11000);
    end else begin
      cyc++;
    end
    k = cyc / 2;
    h = k % H_TOTAL;
    v = (k / H_TOTAL) % V_TOTAL;
    hm = h;
    vm = v;
    col = h >> SCALE_SHIFT;
    row = v >> SCALE_SHIFT;
    in_img = (col < FB_COLS) && (row < FB_ROWS);
    vis = (h < H_VISIBLE) && (v < V_VISIBLE);
    hs = !((h >= H_VISIBLE + H_FRONT) && (h < H_VISIBLE + H_FRONT + H_SYNC));
    vs = !((v >= V_VISIBLE + V_FRONT) && (v < V_VISIBLE + V_FRONT + V_SYNC));
    a = in_img ? 14'(row * FB_COLS + col) : 14'd0;
    rgb = (in_img && vis) ? cell_color(a) : 3'b000;
    exp_addr = addr_q.pop_front();
    addr_q.push_back(a);
    exp_pix = pix_q.pop_front();
    pix_q.push_back({hs, vs, rgb});
    exp_fs = (cyc >= 2) && (cyc % 2 == 0) && (k % (H_TOTAL * V_TOTAL) == 0);
    @(negedge Clock);
  endtask

  task automatic test_reset();
    logic [13:0] want;
    Reset = 1'b1;
    repeat (5) begin
      tick();
      n_cmp++;
      if ({oFbAddress, oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFrameStart} !== {14'd0, 5'b11000, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold: got addr=%0d hs/vs/rgb=%b fs=%b, want 0 11000 0", oFbAddress,
                 {oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B}, oFrameStart);
      end
    end
    Reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      n_cmp++;
      if ({oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFbAddress, oFrameStart} !== {exp_pix, exp_addr, exp_fs}) begin
        n_bad++;
        $display("FAIL sb_reset cyc=%0d: got %b/%0d/%b want %b/%0d/%b", cyc,
                 {oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B}, oFbAddress, oFrameStart, exp_pix, exp_addr, exp_fs);
      end
      // hcount reaches 4 at the 8th edge after release only if counting starts on the 2nd edge
      if (cyc == 9 || cyc == 10) begin
        want = (cyc == 10) ? 14'd1 : 14'd0;
        n_cmp++;
        if (oFbAddress !== want) begin
          n_bad++;
          $display("FAIL first_count cyc=%0d: got addr=%0d want %0d", cyc, oFbAddress, want);
        end
      end
    end
  endtask

  task automatic test_address();
    int spot_v[7] = '{0, 0, 0, 4, 4, 7, 8};
    int spot_h[7] = '{8, 396, 400, 0, 4, 396, 0};
    int spot_a[7] = '{2, 99, 0, 100, 101, 199, 0};
    int sc;
    while (cyc < 2 * 8 * H_TOTAL + 8) begin
      tick();
      n_cmp++;
      if ({oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFbAddress, oFrameStart} !== {exp_pix, exp_addr, exp_fs}) begin
        n_bad++;
        $display("FAIL sb_address cyc=%0d: got %b/%0d/%b want %b/%0d/%b", cyc,
                 {oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B}, oFbAddress, oFrameStart, exp_pix, exp_addr, exp_fs);
      end
      for (int j = 0; j < 7; j++) begin
        sc = 2 * (spot_v[j] * H_TOTAL + spot_h[j]) + 2;
        if (cyc == sc || cyc == sc + 1) begin
          n_cmp++;
          if (oFbAddress !== 14'(spot_a[j])) begin
            n_bad++;
            $display("FAIL addr_spot v=%0d h=%0d: got %0d want %0d", spot_v[j], spot_h[j], oFbAddress, spot_a[j]);
          end
        end
      end
    end
  endtask

  task automatic test_hsync();
    logic prev;
    int last_fall, n_fall;
    prev = oVGA_HS;
    last_fall = -1;
    n_fall = 0;
    while (cyc < 10 * LINE_CLK) begin
      tick();
      n_cmp++;
      if ({oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFbAddress, oFrameStart} !== {exp_pix, exp_addr, exp_fs}) begin
        n_bad++;
        $display("FAIL sb_hsync cyc=%0d: got %b/%0d/%b want %b/%0d/%b", cyc,
                 {oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B}, oFbAddress, oFrameStart, exp_pix, exp_addr, exp_fs);
      end
      if (prev && !oVGA_HS) begin
        n_fall++;
        n_cmp++;
        if ((cyc - HS_FALL0) % LINE_CLK !== 0) begin
          n_bad++;
          $display("FAIL hs_fall_phase: fell at cyc=%0d, want %0d mod %0d", cyc, HS_FALL0, LINE_CLK);
        end
        if (last_fall >= 0) begin
          n_cmp++;
          if (cyc - last_fall !== LINE_CLK) begin
            n_bad++;
            $display("FAIL hs_period: got %0d want %0d", cyc - last_fall, LINE_CLK);
          end
        end
        last_fall = cyc;
      end else if (!prev && oVGA_HS && last_fall >= 0) begin
        n_cmp++;
        if (cyc - last_fall !== 2 * H_SYNC) begin
          n_bad++;
          $display("FAIL hs_low_width: got %0d want %0d", cyc - last_fall, 2 * H_SYNC);
        end
      end
      prev = oVGA_HS;
    end
    n_cmp++;
    if (n_fall !== 2) begin
      n_bad++;
      $display("FAIL hs_fall_count: got %0d want 2", n_fall);
    end
  endtask

  task automatic test_frame_timing();
    logic prev_vs;
    int last_vs, n_vs, last_fs, n_fs;
    prev_vs = oVGA_VS;
    last_vs = -1; n_vs = 0; last_fs = -1; n_fs = 0;
    while (cyc < 2 * FRAME_CLK + 100) begin
      tick();
      n_cmp++;
      if ({oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFbAddress, oFrameStart} !== {exp_pix, exp_addr, exp_fs}) begin
        n_bad++;
        $display("FAIL sb_frame cyc=%0d: got %b/%0d/%b want %b/%0d/%b", cyc,
                 {oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B}, oFbAddress, oFrameStart, exp_pix, exp_addr, exp_fs);
      end
      if (prev_vs && !oVGA_VS) begin
        n_vs++;
        n_cmp++;
        if ((cyc - VS_FALL0) % FRAME_CLK !== 0) begin
          n_bad++;
          $display("FAIL vs_fall_phase: fell at cyc=%0d, want %0d mod %0d", cyc, VS_FALL0, FRAME_CLK);
        end
        if (last_vs >= 0) begin
          n_cmp++;
          if (cyc - last_vs !== FRAME_CLK) begin
            n_bad++;
            $display("FAIL vs_period: got %0d want %0d", cyc - last_vs, FRAME_CLK);
          end
        end
        last_vs = cyc;
      end else if (!prev_vs && oVGA_VS && last_vs >= 0) begin
        n_cmp++;
        if (cyc - last_vs !== V_SYNC * LINE_CLK) begin
          n_bad++;
          $display("FAIL vs_low_width: got %0d want %0d", cyc - last_vs, V_SYNC * LINE_CLK);
        end
      end
      prev_vs = oVGA_VS;
      if (oFrameStart) begin
        n_fs++;
        n_cmp++;
        if (cyc % FRAME_CLK !== 0) begin
          n_bad++;
          $display("FAIL frame_pulse_phase: pulse at cyc=%0d, want multiple of %0d", cyc, FRAME_CLK);
        end
        last_fs = cyc;
      end
    end
    n_cmp++;
    if (n_vs !== 2 || n_fs !== 2 || last_fs !== 2 * FRAME_CLK) begin
      n_bad++;
      $display("FAIL frame_counts: vs falls=%0d pulses=%0d last=%0d, want 2 2 %0d", n_vs, n_fs, last_fs, 2 * FRAME_CLK);
    end
  endtask

  task automatic test_masking();
    int on_cnt;
    on_cnt = 0;
    all_ones = 1'b1;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    while (cyc < FRAME_CLK) begin
      tick();
      n_cmp++;
      if ({oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFbAddress, oFrameStart} !== {exp_pix, exp_addr, exp_fs}) begin
        n_bad++;
        $display("FAIL sb_mask cyc=%0d: got %b/%0d/%b want %b/%0d/%b", cyc,
                 {oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B}, oFbAddress, oFrameStart, exp_pix, exp_addr, exp_fs);
      end
      if ({oVGA_R, oVGA_G, oVGA_B} === 3'b111) on_cnt++;
    end
    n_cmp++;
    if (on_cnt !== 2 * (FB_COLS << SCALE_SHIFT) * (FB_ROWS << SCALE_SHIFT)) begin
      n_bad++;
      $display("FAIL mask_lit_count: got %0d want %0d", on_cnt, 2 * (FB_COLS << SCALE_SHIFT) * (FB_ROWS << SCALE_SHIFT));
    end
  endtask

  task automatic test_reset_midframe();
    while (!(vm == 2 && hm == 300) && cyc < 2 * FRAME_CLK) begin
      tick();
      n_cmp++;
      if ({oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFbAddress, oFrameStart} !== {exp_pix, exp_addr, exp_fs}) begin
        n_bad++;
        $display("FAIL sb_pre_reset cyc=%0d: got %b/%0d/%b want %b/%0d/%b", cyc,
                 {oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B}, oFbAddress, oFrameStart, exp_pix, exp_addr, exp_fs);
      end
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++;
    if ({oFbAddress, oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFrameStart} !== {14'd0, 5'b11000, 1'b0}) begin
      n_bad++;
      $display("FAIL midframe_reset: got addr=%0d hs/vs/rgb=%b fs=%b, want 0 11000 0", oFbAddress,
               {oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B}, oFrameStart);
    end
    repeat (2 * LINE_CLK + 20) begin
      tick();
      n_cmp++;
      if ({oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B, oFbAddress, oFrameStart} !== {exp_pix, exp_addr, exp_fs}) begin
        n_bad++;
        $display("FAIL sb_restart cyc=%0d: got %b/%0d/%b want %b/%0d/%b", cyc,
                 {oVGA_HS, oVGA_VS, oVGA_R, oVGA_G, oVGA_B}, oFbAddress, oFrameStart, exp_pix, exp_addr, exp_fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_address();
    test_hsync();
    test_frame_timing();
    test_masking();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
